// File: rtl/mips_pkg.sv
// Shared MIPS definitions: instruction field layout, opcode/funct encodings,
// fetch-stage reset constants and the small helpers used by the fetch stage.
package mips_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    // Instruction field positions (msb/lsb) and widths
    localparam int unsigned OPCODE_MSB  = 31;
    localparam int unsigned OPCODE_LSB  = 26;
    localparam int unsigned RS_MSB      = 25;
    localparam int unsigned RS_LSB      = 21;
    localparam int unsigned RT_MSB      = 20;
    localparam int unsigned RT_LSB      = 16;
    localparam int unsigned RD_MSB      = 15;
    localparam int unsigned RD_LSB      = 11;
    localparam int unsigned SHAMT_MSB   = 10;
    localparam int unsigned SHAMT_LSB   = 6;
    localparam int unsigned FUNCT_MSB   = 5;
    localparam int unsigned FUNCT_LSB   = 0;

    localparam int unsigned OPCODE_W    = 6;
    localparam int unsigned REG_W       = 5;
    localparam int unsigned SHAMT_W     = 5;
    localparam int unsigned FUNCT_W     = 6;
    localparam int unsigned IMM_W       = 16;
    localparam int unsigned JADDR_W     = 26;

    localparam int unsigned IMEM_WORDS  = 128;
    localparam int unsigned IMEM_IDX_W  = 7;

    // Opcodes recognised by decode
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type funct codes recognised by decode
    localparam logic [5:0] FUNCT_SLL  = 6'h00;
    localparam logic [5:0] FUNCT_SRL  = 6'h02;
    localparam logic [5:0] FUNCT_JR   = 6'h08;
    localparam logic [5:0] FUNCT_ADD  = 6'h20;
    localparam logic [5:0] FUNCT_ADDU = 6'h21;
    localparam logic [5:0] FUNCT_SUB  = 6'h22;
    localparam logic [5:0] FUNCT_AND  = 6'h24;
    localparam logic [5:0] FUNCT_OR   = 6'h25;
    localparam logic [5:0] FUNCT_XOR  = 6'h26;
    localparam logic [5:0] FUNCT_NOR  = 6'h27;
    localparam logic [5:0] FUNCT_SLT  = 6'h2A;

    typedef enum logic [1:0] {
        PC_SEL_INC      = 2'd0,
        PC_SEL_HOLD     = 2'd1,
        PC_SEL_REDIRECT = 2'd2
    } pc_sel_e;

    typedef enum logic [1:0] {
        IFID_LOAD   = 2'd0,
        IFID_HOLD   = 2'd1,
        IFID_BUBBLE = 2'd2
    } ifid_op_e;

    typedef struct packed {
        logic [31:0] instruction;
        logic [31:0] pc_plus4;
        logic        valid;
    } if_id_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

    // Wraps modulo 2^32 by construction of the 32-bit result
    function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

    function automatic logic [5:0] opcode_of(input logic [31:0] instr);
        return instr[OPCODE_MSB:OPCODE_LSB];
    endfunction

    function automatic logic [5:0] funct_of(input logic [31:0] instr);
        return instr[FUNCT_MSB:FUNCT_LSB];
    endfunction

endpackage

// File: rtl/instruction_fetch_if_id_reg.sv
// IF/ID pipeline register: captures instruction and PC+4, with hold and
// bubble (flush) controls; flush takes priority over hold.
module if_id_reg
    import mips_pkg::*;
#(
    parameter logic [31:0] NOP_WORD = NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        hold,
    input  logic        flush,
    input  logic [31:0] instruction_in,
    input  logic [31:0] pc_plus4_in,
    output logic [31:0] instruction,
    output logic [31:0] pc_plus4,
    output logic        valid
);

    if_id_t ifid_q;
    if_id_t ifid_d;

    always_comb begin
        ifid_d = ifid_q;
        if (flush) begin
            ifid_d.instruction = NOP_WORD;
            ifid_d.pc_plus4    = 32'd0;
            ifid_d.valid       = 1'b0;
        end else if (!hold) begin
            ifid_d.instruction = instruction_in;
            ifid_d.pc_plus4    = pc_plus4_in;
            ifid_d.valid       = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ifid_q.instruction <= NOP_WORD;
            ifid_q.pc_plus4    <= 32'd0;
            ifid_q.valid       <= 1'b0;
        end else begin
            ifid_q <= ifid_d;
        end
    end

    assign instruction = ifid_q.instruction;
    assign pc_plus4    = ifid_q.pc_plus4;
    assign valid       = ifid_q.valid;

endmodule

// File: rtl/instruction_fetch.sv
// MIPS instruction fetch stage: owns the PC, drives the instruction memory
// address and feeds the IF/ID register; handles stall, flush and redirect.
module instruction_fetch
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter logic [31:0] NOP_WORD = NOP_INSTR
) (
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic        Stall,
    input  logic        Flush,
    input  logic        Redirect,
    input  logic [31:0] RedirectTarget,
    output logic [31:0] ImemAddress,
    input  logic [31:0] ImemInstruction,
    output logic [31:0] IfId_Instruction,
    output logic [31:0] IfId_PCPlus4,
    output logic        IfId_Valid,
    output logic [31:0] FetchCount
);

    localparam logic [31:0] RESET_PC_ALIGNED = word_align(RESET_PC);
    localparam logic [31:0] COUNT_MAX        = 32'hFFFF_FFFF;

    logic [31:0] pc_q;
    logic [31:0] pc_d;
    logic [31:0] pc_next_seq;
    logic [31:0] fetch_count_q;
    logic [31:0] fetch_count_d;
    pc_sel_e     pc_sel;
    ifid_op_e    ifid_op;
    logic        ifid_hold;
    logic        ifid_flush;

    assign pc_next_seq = pc_plus4(pc_q);

    // Redirect outranks stall for both the PC and IF/ID; flush only bubbles IF/ID
    always_comb begin
        pc_sel  = PC_SEL_INC;
        ifid_op = IFID_LOAD;
        if (Redirect) begin
            pc_sel = PC_SEL_REDIRECT;
        end else if (Stall) begin
            pc_sel = PC_SEL_HOLD;
        end
        if (Redirect || Flush) begin
            ifid_op = IFID_BUBBLE;
        end else if (Stall) begin
            ifid_op = IFID_HOLD;
        end
    end

    always_comb begin
        pc_d = pc_next_seq;
        case (pc_sel)
            PC_SEL_REDIRECT: pc_d = word_align(RedirectTarget);
            PC_SEL_HOLD:     pc_d = pc_q;
            default:         pc_d = pc_next_seq;
        endcase
    end

    always_comb begin
        fetch_count_d = fetch_count_q;
        if (ifid_op == IFID_LOAD && fetch_count_q != COUNT_MAX) begin
            fetch_count_d = fetch_count_q + 32'd1;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            pc_q          <= RESET_PC_ALIGNED;
            fetch_count_q <= 32'd0;
        end else begin
            pc_q          <= pc_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    assign ifid_hold  = (ifid_op == IFID_HOLD);
    assign ifid_flush = (ifid_op == IFID_BUBBLE);

    if_id_reg #(
        .NOP_WORD (NOP_WORD)
    ) u_if_id_reg (
        .clk            (Clk),
        .rst_n          (Rst_n),
        .hold           (ifid_hold),
        .flush          (ifid_flush),
        .instruction_in (ImemInstruction),
        .pc_plus4_in    (pc_next_seq),
        .instruction    (IfId_Instruction),
        .pc_plus4       (IfId_PCPlus4),
        .valid          (IfId_Valid)
    );

    assign ImemAddress = pc_q;
    assign FetchCount  = fetch_count_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed, table-driven bench for instruction_fetch with a 128-word
// combinational instruction memory model.
module tb_instruction_fetch;

    logic        Clk = 1'b0;
    logic        Rst_n;
    logic        Stall;
    logic        Flush;
    logic        Redirect;
    logic [31:0] RedirectTarget;
    logic [31:0] ImemAddress;
    logic [31:0] ImemInstruction;
    logic [31:0] IfId_Instruction;
    logic [31:0] IfId_PCPlus4;
    logic        IfId_Valid;
    logic [31:0] FetchCount;

    logic [31:0] mem [128];
    int          checks = 0;
    int          errors = 0;

    typedef struct {
        logic        stall;
        logic        flush;
        logic        redirect;
        logic [31:0] target;
        logic [31:0] exp_pc;
        logic [31:0] exp_instr;
        logic [31:0] exp_pcp4;
        logic        exp_valid;
        logic [31:0] exp_count;
    } vec_t;

    vec_t vecs[$];

    instruction_fetch #(
        .RESET_PC (32'h0000_0000),
        .NOP_WORD (32'h0000_0000)
    ) dut (
        .Clk              (Clk),
        .Rst_n            (Rst_n),
        .Stall            (Stall),
        .Flush            (Flush),
        .Redirect         (Redirect),
        .RedirectTarget   (RedirectTarget),
        .ImemAddress      (ImemAddress),
        .ImemInstruction  (ImemInstruction),
        .IfId_Instruction (IfId_Instruction),
        .IfId_PCPlus4     (IfId_PCPlus4),
        .IfId_Valid       (IfId_Valid),
        .FetchCount       (FetchCount)
    );

    always #5 Clk = ~Clk;

    assign ImemInstruction = mem[ImemAddress[8:2]];

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all(input string tag, input logic [31:0] pc, input logic [31:0] instr,
                             input logic [31:0] pcp4, input logic valid, input logic [31:0] count);
        check_output({tag, " pc"},    ImemAddress,      pc);
        check_output({tag, " instr"}, IfId_Instruction, instr);
        check_output({tag, " pcp4"},  IfId_PCPlus4,     pcp4);
        check_output({tag, " valid"}, {31'd0, IfId_Valid}, {31'd0, valid});
        check_output({tag, " count"}, FetchCount,       count);
    endtask

    task automatic apply_stimulus(input logic st, input logic fl, input logic rd, input logic [31:0] tgt);
        Stall          = st;
        Flush          = fl;
        Redirect       = rd;
        RedirectTarget = tgt;
    endtask

    task automatic add_vec(input logic st, input logic fl, input logic rd, input logic [31:0] tgt,
                           input logic [31:0] pc, input logic [31:0] instr, input logic [31:0] pcp4,
                           input logic valid, input logic [31:0] count);
        vec_t v;
        v.stall = st; v.flush = fl; v.redirect = rd; v.target = tgt;
        v.exp_pc = pc; v.exp_instr = instr; v.exp_pcp4 = pcp4;
        v.exp_valid = valid; v.exp_count = count;
        vecs.push_back(v);
    endtask

    initial begin
        for (int i = 0; i < 128; i++) begin
            mem[i] = 32'hAC00_0000 | (i << 2);
        end
        mem[0] = 32'h0000_0000;
        mem[1] = 32'h2008_0064;
        mem[2] = 32'h2009_0002;
        mem[3] = 32'h200A_000A;

        //      st    fl    rd    target          pc            instr         pcp4          v     count
        add_vec(1'b0, 1'b0, 1'b0, 32'h0,          32'h0000_0004, 32'h0000_0000, 32'h0000_0004, 1'b1, 32'd1);
        add_vec(1'b0, 1'b0, 1'b0, 32'h0,          32'h0000_0008, 32'h2008_0064, 32'h0000_0008, 1'b1, 32'd2);
        add_vec(1'b1, 1'b0, 1'b0, 32'h0,          32'h0000_0008, 32'h2008_0064, 32'h0000_0008, 1'b1, 32'd2);
        add_vec(1'b1, 1'b0, 1'b0, 32'h0,          32'h0000_0008, 32'h2008_0064, 32'h0000_0008, 1'b1, 32'd2);
        add_vec(1'b1, 1'b0, 1'b0, 32'h0,          32'h0000_0008, 32'h2008_0064, 32'h0000_0008, 1'b1, 32'd2);
        add_vec(1'b0, 1'b0, 1'b0, 32'h0,          32'h0000_000C, 32'h2009_0002, 32'h0000_000C, 1'b1, 32'd3);
        add_vec(1'b0, 1'b0, 1'b1, 32'h0000_000E,  32'h0000_000C, 32'h0000_0000, 32'h0000_0000, 1'b0, 32'd3);
        add_vec(1'b0, 1'b0, 1'b0, 32'h0,          32'h0000_0010, 32'h200A_000A, 32'h0000_0010, 1'b1, 32'd4);
        add_vec(1'b1, 1'b1, 1'b0, 32'h0,          32'h0000_0010, 32'h0000_0000, 32'h0000_0000, 1'b0, 32'd4);
        add_vec(1'b0, 1'b0, 1'b0, 32'h0,          32'h0000_0014, 32'hAC00_0010, 32'h0000_0014, 1'b1, 32'd5);
        add_vec(1'b1, 1'b0, 1'b1, 32'h0000_0004,  32'h0000_0004, 32'h0000_0000, 32'h0000_0000, 1'b0, 32'd5);
        add_vec(1'b0, 1'b0, 1'b0, 32'h0,          32'h0000_0008, 32'h2008_0064, 32'h0000_0008, 1'b1, 32'd6);
        add_vec(1'b0, 1'b1, 1'b0, 32'h0,          32'h0000_000C, 32'h0000_0000, 32'h0000_0000, 1'b0, 32'd6);
        add_vec(1'b0, 1'b0, 1'b0, 32'h0,          32'h0000_0010, 32'h200A_000A, 32'h0000_0010, 1'b1, 32'd7);
        add_vec(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFE,  32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0000, 1'b0, 32'd7);
        add_vec(1'b0, 1'b0, 1'b0, 32'h0,          32'h0000_0000, 32'hAC00_01FC, 32'h0000_0000, 1'b1, 32'd8);
        add_vec(1'b0, 1'b0, 1'b0, 32'h0,          32'h0000_0004, 32'h0000_0000, 32'h0000_0004, 1'b1, 32'd9);

        Rst_n = 1'b0;
        apply_stimulus(1'b0, 1'b0, 1'b0, 32'h0);
        #1;
        check_all("reset", 32'h0, 32'h0, 32'h0, 1'b0, 32'd0);
        repeat (2) @(posedge Clk);
        #1;
        check_all("reset held", 32'h0, 32'h0, 32'h0, 1'b0, 32'd0);

        @(negedge Clk);
        Rst_n = 1'b1;
        foreach (vecs[i]) begin
            apply_stimulus(vecs[i].stall, vecs[i].flush, vecs[i].redirect, vecs[i].target);
            @(posedge Clk);
            #1;
            check_all($sformatf("vec%0d", i), vecs[i].exp_pc, vecs[i].exp_instr,
                      vecs[i].exp_pcp4, vecs[i].exp_valid, vecs[i].exp_count);
            @(negedge Clk);
        end

        // A redirect pulse that is gone by the edge must not be seen
        apply_stimulus(1'b0, 1'b0, 1'b1, 32'h0000_0040);
        #2;
        apply_stimulus(1'b0, 1'b0, 1'b0, 32'h0);
        @(posedge Clk);
        #1;
        check_all("glitch", 32'h0000_0008, 32'h2008_0064, 32'h0000_0008, 1'b1, 32'd10);

        // Asynchronous reset mid-cycle while redirect and stall are asserted
        @(negedge Clk);
        apply_stimulus(1'b1, 1'b0, 1'b1, 32'h0000_0020);
        #2;
        Rst_n = 1'b0;
        #1;
        check_all("async reset", 32'h0, 32'h0, 32'h0, 1'b0, 32'd0);
        @(posedge Clk);
        #1;
        check_all("reset dominates", 32'h0, 32'h0, 32'h0, 1'b0, 32'd0);
        @(negedge Clk);
        apply_stimulus(1'b0, 1'b0, 1'b0, 32'h0);
        Rst_n = 1'b1;
        @(posedge Clk);
        #1;
        check_all("post reset", 32'h0000_0004, 32'h0000_0000, 32'h0000_0004, 1'b1, 32'd1);
        @(posedge Clk);
        #1;
        check_all("post reset 2", 32'h0000_0008, 32'h2008_0064, 32'h0000_0008, 1'b1, 32'd2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
